// File: rtl/key_bounce_gen_pkg.sv
// Shared types and timing constants for the emulated key source and the debounce filter it feeds.
// Defaults assume a 50 MHz system clock.
package key_bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    P_BOUNCE = 2'd1,
    HOLD     = 2'd2,
    R_BOUNCE = 2'd3
  } kb_state_t;

  // Fibonacci feedback taps for x^16+x^14+x^13+x^11+1 (stages 16,14,13,11 -> bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  localparam logic [19:0] BOUNCE_MAX_DEF    = 20'd249_999;   // 5 ms
  localparam logic [23:0] HOLD_MAX_DEF      = 24'd4_999_999; // 100 ms
  localparam logic [19:0] DEBOUNCE_20MS_MAX = 20'd999_999;   // debounce filter window
  localparam int unsigned SEG_W_DEF         = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR supplying the random bounce segment lengths.
module lfsr16
  import key_bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [15:0] state
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= SEED;
    else            state <= lfsr_next(state);
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Emulated mechanical key: one press_req yields a bouncy fall, a stable low hold and a bouncy rise.
// Bounce segment lengths come from a free-running LFSR, so a fixed seed gives a repeatable waveform.
module key_bounce_gen
  import key_bounce_gen_pkg::*;
#(
  parameter logic [19:0] BOUNCE_MAX = BOUNCE_MAX_DEF,
  parameter logic [23:0] HOLD_MAX   = HOLD_MAX_DEF,
  parameter int unsigned SEG_W      = SEG_W_DEF,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic press_req,
  output logic key_out,
  output logic busy,
  output logic done
);

  if (LFSR_SEED == 16'h0000) begin : g_seed_check
    $error("LFSR_SEED must be non-zero");
  end
  if (SEG_W < 1 || SEG_W > 15) begin : g_seg_check
    $error("SEG_W must be in 1..15");
  end

  localparam logic [SEG_W-1:0] SEG_ONE = SEG_W'(1);

  kb_state_t        state, state_nxt;
  logic [23:0]      cnt, cnt_nxt;
  logic [SEG_W-1:0] seg_cnt, seg_nxt;
  logic             key_nxt, busy_nxt, done_nxt;
  logic [15:0]      lfsr;
  logic [SEG_W-1:0] seg_load;
  logic             bounce_end, hold_end;
  logic             unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .state     (lfsr)
  );

  assign seg_load         = lfsr[SEG_W-1:0];
  assign unused_lfsr_bits = ^lfsr[15:SEG_W];
  assign bounce_end       = (cnt == {4'd0, BOUNCE_MAX});
  assign hold_end         = (cnt == HOLD_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      seg_cnt <= '0;
      key_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      seg_cnt <= seg_nxt;
      key_out <= key_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (press_req)  state_nxt = P_BOUNCE;
      P_BOUNCE: if (bounce_end) state_nxt = HOLD;
      HOLD:     if (hold_end)   state_nxt = R_BOUNCE;
      R_BOUNCE: if (bounce_end) state_nxt = IDLE;
    endcase
  end

  // The last clock of a bounce window never toggles; it forces the settled level instead.
  always_comb begin
    cnt_nxt  = cnt;
    seg_nxt  = seg_cnt;
    key_nxt  = key_out;
    busy_nxt = busy;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        key_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (press_req) begin
          key_nxt  = 1'b0;
          busy_nxt = 1'b1;
          cnt_nxt  = '0;
          seg_nxt  = seg_load;
        end
      end
      P_BOUNCE, R_BOUNCE: begin
        cnt_nxt = cnt + 24'd1;
        if (seg_cnt == '0 && !bounce_end) begin
          key_nxt = ~key_out;
          seg_nxt = seg_load;
        end else begin
          seg_nxt = seg_cnt - SEG_ONE;
        end
        if (bounce_end) begin
          cnt_nxt = '0;
          if (state == P_BOUNCE) begin
            key_nxt = 1'b0;
          end else begin
            key_nxt  = 1'b1;
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        key_nxt = 1'b0;
        cnt_nxt = cnt + 24'd1;
        if (hold_end) begin
          key_nxt = 1'b1;
          cnt_nxt = '0;
          seg_nxt = seg_load;
        end
      end
    endcase
  end

endmodule
